load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data-memory port: accepts one load/store request at a time from the
//  core over a valid/ready handshake, checks alignment, address range and access type, drives
//  the DataMemory port (ren/wen/rwtype/addr/wdata/sign_extend) for a fixed number of cycles,
//  then returns a one-cycle response with read data or an address-error code (MIPS AdEL/AdES).
// PARAMETERS
//  WAIT_CYCLES  1             extra ACCESS cycles before load data is sampled (0..15)
//  DMEM_LO      32'h1001_0000 lowest legal byte address (inclusive)
//  DMEM_HI      32'h7FFF_FFFF highest legal byte address (inclusive; whole access must fit)
// PORTS
//  clk            in   1   clock, all state on posedge
//  rst            in   1   synchronous, active-high reset
//  req_valid      in   1   core request valid
//  req_ready      out  1   unit can accept (IDLE only)
//  req_write      in   1   1=store, 0=load
//  req_type       in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_signed     in   1   load sign-extension (ignored for stores/word)
//  req_addr       in   32  byte address
//  req_wdata      in   32  store data, right-justified
//  resp_valid     out  1   one-cycle response strobe
//  resp_rdata     out  32  load result (0 for stores and errors)
//  resp_err       out  1   request rejected, no memory access made
//  resp_errcode   out  2   00 none, 01 misaligned load, 10 misaligned store, 11 range/type
//  resp_badvaddr  out  32  faulting address (0 when resp_err=0)
//  dm_ren         out  1   to DataMemory ren
//  dm_wen         out  1   to DataMemory wen
//  dm_rwtype      out  2   to DataMemory rwtype
//  dm_addr        out  32  to DataMemory addr
//  dm_wdata       out  32  to DataMemory wdata
//  dm_sign_extend out  1   to DataMemory sign_extend
//  dm_rdata       in   32  from DataMemory rdata (combinational read)
// BEHAVIOUR
//  Reset: state IDLE, req_ready=1, every other output 0, wait counter 0, latched request 0.
//  FSM IDLE -> (ACCESS | RESP) -> IDLE.
//  IDLE: req_ready=1; on req_valid&req_ready latch write/type/signed/addr/wdata, classify:
//   - type 11, or addr<DMEM_LO, or addr+size-1>DMEM_HI            -> RESP, code 11
//   - half with addr[0]!=0, word with addr[1:0]!=0                -> RESP, code 01 load / 10 store
//   - otherwise -> ACCESS, counter=WAIT_CYCLES. Range checked before alignment.
//  ACCESS: dm_addr/dm_rwtype/dm_wdata/dm_sign_extend driven from latched request, else 0.
//   - load: dm_ren=1 every ACCESS cycle; store: dm_wen=1 only in first ACCESS cycle.
//   - counter!=0 -> decrement, stay; counter==0 -> load: resp_rdata<=dm_rdata; go RESP.
//  RESP: resp_valid=1 for exactly one cycle, no backpressure; next cycle IDLE.
//  Latency (handshake cycle=0): ok access resp_valid in cycle 2+WAIT_CYCLES; error in cycle 1.
//  Max throughput: one request per 3+WAIT_CYCLES cycles (2 on error).
//  req_ready=0 in ACCESS/RESP; req_* ignored there, request held by core is taken on IDLE.
//  resp_* registered, valid only with resp_valid; cleared to 0 on return to IDLE.
//  dm_wen gated with !rst: no memory write in a cycle where rst=1.
//  Reset mid-operation: aborts at next edge, no response issued, outputs to reset values.
//  Store: dm_wdata = raw req_wdata; memory selects lanes by addr[1:0]; resp_rdata=0.
//  DMEM_HI check uses 33-bit addr+size-1, so wrap past 32'hFFFF_FFFF is range error.
// TESTING
//  1 WAIT=1, sw 0x1001_0000 0xDEADBEEF -> dm_wen=1 one cycle cycle1, rwtype 10; resp_valid cycle3, err 0.
//  2 mem word 0x80FF_1234 @0x1001_0000: lb 0x1001_0003 -> 0xFFFF_FF80; lbu -> 0x0000_0080; lh +2 -> 0xFFFF_80FF.
//  3 lw 0x1001_0002 -> resp cycle1, err 1, code 01, badvaddr 0x1001_0002, dm_ren never 1.
//  4 sh 0x0000_0100 -> code 11 no dm_wen; req_type 11 at legal addr -> code 11.
//  5 req_valid held 3 back-to-back lw, WAIT=0 -> accepted cycles 0,3,6; req_ready low between.
//  6 rst=1 in first ACCESS cycle of sw -> dm_wen 0 that cycle, no resp_valid, IDLE next cycle.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: takes one core request at a time, screens it for range, type and alignment,
// drives the DataMemory port for a fixed number of cycles and returns a one-cycle response.
module load_store_unit #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] DMEM_LO     = 32'h1001_0000,
  parameter logic [31:0] DMEM_HI     = 32'h7FFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_type,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  resp_errcode,
  output logic [31:0] resp_badvaddr,
  output logic        dm_ren,
  output logic        dm_wen,
  output logic [1:0]  dm_rwtype,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_sign_extend,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] TYPE_BYTE = 2'b00;
  localparam logic [1:0] TYPE_HALF = 2'b01;
  localparam logic [1:0] TYPE_WORD = 2'b10;
  localparam logic [1:0] TYPE_BAD  = 2'b11;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ADEL     = 2'b01;
  localparam logic [1:0] ERR_ADES     = 2'b10;
  localparam logic [1:0] ERR_RANGE    = 2'b11;

  state_t      state, state_next;
  logic [3:0]  wait_cnt, wait_cnt_next;
  logic        first_q, first_next;

  logic        lat_write, lat_write_next;
  logic [1:0]  lat_type, lat_type_next;
  logic        lat_signed, lat_signed_next;
  logic [31:0] lat_addr, lat_addr_next;
  logic [31:0] lat_wdata, lat_wdata_next;

  logic [31:0] rdata_q, rdata_next;
  logic        err_q, err_next;
  logic [1:0]  errcode_q, errcode_next;
  logic [31:0] badvaddr_q, badvaddr_next;

  logic [1:0]  size_m1;
  logic [32:0] last_byte;
  logic        range_err;
  logic        misaligned;
  logic        in_access;

  // 33-bit end address so an access that wraps past the top of memory is caught as out of range
  always_comb begin
    size_m1 = 2'd0;
    case (req_type)
      TYPE_HALF: size_m1 = 2'd1;
      TYPE_WORD: size_m1 = 2'd3;
      default:   size_m1 = 2'd0;
    endcase
    last_byte  = {1'b0, req_addr} + {31'b0, size_m1};
    range_err  = (req_type == TYPE_BAD) || (req_addr < DMEM_LO) ||
                 (last_byte > {1'b0, DMEM_HI});
    misaligned = ((req_type == TYPE_HALF) && req_addr[0]) ||
                 ((req_type == TYPE_WORD) && (req_addr[1:0] != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= 4'd0;
      first_q    <= 1'b0;
      lat_write  <= 1'b0;
      lat_type   <= 2'b00;
      lat_signed <= 1'b0;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
      errcode_q  <= ERR_NONE;
      badvaddr_q <= 32'h0;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_cnt_next;
      first_q    <= first_next;
      lat_write  <= lat_write_next;
      lat_type   <= lat_type_next;
      lat_signed <= lat_signed_next;
      lat_addr   <= lat_addr_next;
      lat_wdata  <= lat_wdata_next;
      rdata_q    <= rdata_next;
      err_q      <= err_next;
      errcode_q  <= errcode_next;
      badvaddr_q <= badvaddr_next;
    end
  end

  always_comb begin
    state_next      = state;
    wait_cnt_next   = wait_cnt;
    first_next      = first_q;
    lat_write_next  = lat_write;
    lat_type_next   = lat_type;
    lat_signed_next = lat_signed;
    lat_addr_next   = lat_addr;
    lat_wdata_next  = lat_wdata;
    rdata_next      = rdata_q;
    err_next        = err_q;
    errcode_next    = errcode_q;
    badvaddr_next   = badvaddr_q;

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          lat_write_next  = req_write;
          lat_type_next   = req_type;
          lat_signed_next = req_signed;
          lat_addr_next   = req_addr;
          lat_wdata_next  = req_wdata;
          // Range/type faults take priority over misalignment
          if (range_err) begin
            err_next      = 1'b1;
            errcode_next  = ERR_RANGE;
            badvaddr_next = req_addr;
            rdata_next    = 32'h0;
            state_next    = S_RESP;
          end else if (misaligned) begin
            err_next      = 1'b1;
            errcode_next  = req_write ? ERR_ADES : ERR_ADEL;
            badvaddr_next = req_addr;
            rdata_next    = 32'h0;
            state_next    = S_RESP;
          end else begin
            wait_cnt_next = WAIT_INIT;
            first_next    = 1'b1;
            state_next    = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        first_next = 1'b0;
        if (wait_cnt != 4'd0) begin
          wait_cnt_next = wait_cnt - 4'd1;
        end else begin
          if (!lat_write) begin
            rdata_next = dm_rdata;
          end
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        rdata_next    = 32'h0;
        err_next      = 1'b0;
        errcode_next  = ERR_NONE;
        badvaddr_next = 32'h0;
        state_next    = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign in_access = (state == S_ACCESS);

  assign req_ready     = (state == S_IDLE);
  assign resp_valid    = (state == S_RESP);
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign resp_errcode  = errcode_q;
  assign resp_badvaddr = badvaddr_q;

  // A store writes memory once; rst suppresses that write even mid-cycle
  assign dm_ren         = in_access && !lat_write;
  assign dm_wen         = in_access && lat_write && first_q && !rst;
  assign dm_rwtype      = in_access ? lat_type   : 2'b00;
  assign dm_addr        = in_access ? lat_addr   : 32'h0;
  assign dm_wdata       = in_access ? lat_wdata  : 32'h0;
  assign dm_sign_extend = in_access ? lat_signed : 1'b0;

endmodule
